// File: rtl/tile_pkg.sv
// Shared constants and state encoding for the tile-matching board engine.
// Default layout pairs tile i with tile i+5 (ids 0..4, 3 bits per tile).
package tile_pkg;

  localparam int NUM_TILES = 10;
  localparam int PAIR_W    = 3;
  localparam int IDX_W     = 4;
  localparam logic [NUM_TILES*PAIR_W-1:0] LAYOUT_DEFAULT = 30'h23444688;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ONE   = 3'd1,
    CHECK = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/tile_board_hold_timer.sv
// Loadable down counter for the mismatch display window; load/clear take effect next cycle.
// Decrement stops at zero; zero flag is combinational from the count.
module hold_timer #(
  parameter int WIDTH = 25
) (
  input  logic             CLOCK_50,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] loadValue,
  input  logic             dec,
  output logic [WIDTH-1:0] value,
  output logic             zero
);

  always_ff @(posedge CLOCK_50) begin
    if (clear)
      value <= '0;
    else if (load)
      value <= loadValue;
    else if (dec && value != '0)
      value <= value - 1'b1;
  end

  assign zero = (value == '0);

endmodule

// File: rtl/tile_board.sv
// Board-state engine: tracks tiles down/up/matched, compares flipped pairs, holds mismatches.
// Flip shows next cycle, result 2 cycles after second flip; flips while busy or done are dropped.
module tile_board #(
  parameter int NUM_TILES = tile_pkg::NUM_TILES,
  parameter logic [NUM_TILES*tile_pkg::PAIR_W-1:0] LAYOUT = tile_pkg::LAYOUT_DEFAULT,
  parameter int HOLD_CYCLES = 25_000_000
) (
  input  logic                 CLOCK_50,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 flip_req,
  input  logic [3:0]           flip_idx,
  output logic [NUM_TILES-1:0] tile_up,
  output logic [NUM_TILES-1:0] tile_matched,
  output logic [2:0]           matched_pairs,
  output logic                 all_matched,
  output logic [7:0]           moves,
  output logic                 mismatch,
  output logic                 busy
);

  import tile_pkg::*;

  localparam int TIMER_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [2:0] PAIRS_L = 3'(NUM_TILES / 2);
  localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'(HOLD_CYCLES - 1);

  state_t state;
  logic [IDX_W-1:0] first, second;
  logic [PAIR_W-1:0] pairIds [NUM_TILES];
  logic flipOk, pairMatch, timerZero;
  logic [TIMER_W-1:0] timerValue;

  for (genvar i = 0; i < NUM_TILES; i++) begin : g_ids
    assign pairIds[i] = LAYOUT[PAIR_W*i +: PAIR_W];
  end

  // Range check first so the tile bit lookups only matter for real tiles.
  assign flipOk = flip_req && ({1'b0, flip_idx} < 5'(NUM_TILES))
                  && !tile_up[flip_idx] && !tile_matched[flip_idx];
  assign pairMatch = (pairIds[first] == pairIds[second]);

  hold_timer #(.WIDTH(TIMER_W)) u_timer (
    .CLOCK_50 (CLOCK_50),
    .clear    (!resetn || start),
    .load     (state == CHECK && !pairMatch),
    .loadValue(HOLD_LOAD),
    .dec      (state == HOLD),
    .value    (timerValue),
    .zero     (timerZero)
  );

  always_ff @(posedge CLOCK_50) begin
    mismatch <= 1'b0;
    if (!resetn || start) begin
      state         <= IDLE;
      tile_up       <= '0;
      tile_matched  <= '0;
      matched_pairs <= '0;
      all_matched   <= 1'b0;
      moves         <= '0;
      busy          <= 1'b0;
      first         <= '0;
      second        <= '0;
    end else begin
      case (state)
        IDLE: if (flipOk) begin
          tile_up[flip_idx] <= 1'b1;
          first             <= flip_idx;
          state             <= ONE;
        end
        ONE: if (flipOk) begin
          tile_up[flip_idx] <= 1'b1;
          second            <= flip_idx;
          if (moves != 8'hFF)
            moves <= moves + 8'd1;
          busy  <= 1'b1;
          state <= CHECK;
        end
        CHECK: if (pairMatch) begin
          tile_matched[first]  <= 1'b1;
          tile_matched[second] <= 1'b1;
          tile_up[first]       <= 1'b0;
          tile_up[second]      <= 1'b0;
          matched_pairs        <= matched_pairs + 3'd1;
          busy                 <= 1'b0;
          if (3'(matched_pairs + 3'd1) == PAIRS_L) begin
            all_matched <= 1'b1;
            state       <= DONE;
          end else begin
            state <= IDLE;
          end
        end else begin
          mismatch <= 1'b1;
          state    <= HOLD;
        end
        HOLD: if (timerZero) begin
          tile_up[first]  <= 1'b0;
          tile_up[second] <= 1'b0;
          busy            <= 1'b0;
          state           <= IDLE;
        end
        DONE: tile_up <= '0;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_board.sv
// Directed bench for tile_board with a 4-cycle mismatch hold.
// Cycle table for match/mismatch/illegal flips, plus hand sequences for full game, start abort, saturation.
module tb_tile_board;

  logic CLOCK_50 = 1'b0;
  logic resetn, start, flip_req;
  logic [3:0] flip_idx;
  logic [9:0] tile_up, tile_matched;
  logic [2:0] matched_pairs;
  logic all_matched, mismatch, busy;
  logic [7:0] moves;

  int checks = 0;
  int errors = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  tile_board #(.HOLD_CYCLES(4)) dut (
    .CLOCK_50     (CLOCK_50),
    .resetn       (resetn),
    .start        (start),
    .flip_req     (flip_req),
    .flip_idx     (flip_idx),
    .tile_up      (tile_up),
    .tile_matched (tile_matched),
    .matched_pairs(matched_pairs),
    .all_matched  (all_matched),
    .moves        (moves),
    .mismatch     (mismatch),
    .busy         (busy)
  );

  typedef struct {
    logic       st;
    logic       fr;
    logic [3:0] idx;
    logic [9:0] up;
    logic [9:0] mt;
    logic [2:0] pr;
    logic [7:0] mv;
    logic       bz;
    logic       mis;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(logic st, logic fr, logic [3:0] idx, logic [9:0] up,
                              logic [9:0] mt, logic [2:0] pr, logic [7:0] mv,
                              logic bz, logic mis);
    vec_t v;
    v.st = st; v.fr = fr; v.idx = idx; v.up = up; v.mt = mt;
    v.pr = pr; v.mv = mv; v.bz = bz; v.mis = mis;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge CLOCK_50);
  endtask

  task automatic doFlip(input logic [3:0] idx);
    flip_req = 1'b1;
    flip_idx = idx;
    tick();
    flip_req = 1'b0;
  endtask

  task automatic checkAll(input string tag, input logic [9:0] up, input logic [9:0] mt,
                          input logic [2:0] pr, input logic [7:0] mv, input logic bz,
                          input logic mis, input logic all);
    chk({tag, ".tile_up"}, 32'(tile_up), 32'(up));
    chk({tag, ".tile_matched"}, 32'(tile_matched), 32'(mt));
    chk({tag, ".matched_pairs"}, 32'(matched_pairs), 32'(pr));
    chk({tag, ".moves"}, 32'(moves), 32'(mv));
    chk({tag, ".busy"}, 32'(busy), 32'(bz));
    chk({tag, ".mismatch"}, 32'(mismatch), 32'(mis));
    chk({tag, ".all_matched"}, 32'(all_matched), 32'(all));
  endtask

  task automatic waitIdle();
    for (int k = 0; k < 20 && busy; k++) tick();
    chk("wait_idle.busy", 32'(busy), 32'd0);
  endtask

  initial begin
    // Tile ids: 0..4 for tiles 0..4 and again for tiles 5..9.
    vecs[0]  = mk(0, 1, 4'd0,  10'h001, 10'h000, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 4'd0,  10'h001, 10'h000, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 4'd0,  10'h001, 10'h000, 0, 0, 0, 0);
    vecs[3]  = mk(0, 1, 4'd5,  10'h021, 10'h000, 0, 1, 1, 0);
    vecs[4]  = mk(0, 0, 4'd0,  10'h000, 10'h021, 1, 1, 0, 0);
    vecs[5]  = mk(0, 1, 4'd0,  10'h000, 10'h021, 1, 1, 0, 0);
    vecs[6]  = mk(0, 1, 4'd1,  10'h002, 10'h021, 1, 1, 0, 0);
    vecs[7]  = mk(0, 1, 4'd1,  10'h002, 10'h021, 1, 1, 0, 0);
    vecs[8]  = mk(0, 1, 4'd12, 10'h002, 10'h021, 1, 1, 0, 0);
    vecs[9]  = mk(0, 1, 4'd2,  10'h006, 10'h021, 1, 2, 1, 0);
    vecs[10] = mk(0, 1, 4'd3,  10'h006, 10'h021, 1, 2, 1, 1);
    vecs[11] = mk(0, 0, 4'd0,  10'h006, 10'h021, 1, 2, 1, 0);
    vecs[12] = mk(0, 1, 4'd4,  10'h006, 10'h021, 1, 2, 1, 0);
    vecs[13] = mk(0, 0, 4'd0,  10'h006, 10'h021, 1, 2, 1, 0);
    vecs[14] = mk(0, 0, 4'd0,  10'h000, 10'h021, 1, 2, 0, 0);
    vecs[15] = mk(0, 1, 4'd2,  10'h004, 10'h021, 1, 2, 0, 0);

    resetn = 1'b0; start = 1'b0; flip_req = 1'b0; flip_idx = '0;
    tick(); tick();
    checkAll("reset", 10'h000, 10'h000, 0, 0, 0, 0, 0);
    resetn = 1'b1;

    for (int i = 0; i < 16; i++) begin
      start    = vecs[i].st;
      flip_req = vecs[i].fr;
      flip_idx = vecs[i].idx;
      tick();
      checkAll($sformatf("vec%0d", i), vecs[i].up, vecs[i].mt, vecs[i].pr,
               vecs[i].mv, vecs[i].bz, vecs[i].mis, 1'b0);
    end
    flip_req = 1'b0;

    // Full game: all five pairs, then DONE ignores flips, start clears.
    start = 1'b1; tick(); start = 1'b0;
    checkAll("start_clear", 10'h000, 10'h000, 0, 0, 0, 0, 0);
    for (int p = 0; p < 5; p++) begin
      doFlip(4'(p));
      doFlip(4'(p + 5));
      tick();
      chk($sformatf("game%0d.mismatch", p), 32'(mismatch), 32'd0);
      chk($sformatf("game%0d.pairs", p), 32'(matched_pairs), 32'(p + 1));
    end
    checkAll("done", 10'h000, 10'h3FF, 5, 5, 0, 0, 1);
    doFlip(4'd0);
    tick();
    checkAll("done_flip", 10'h000, 10'h3FF, 5, 5, 0, 0, 1);
    start = 1'b1; tick(); start = 1'b0;
    checkAll("done_start", 10'h000, 10'h000, 0, 0, 0, 0, 0);

    // Start coincident with the second flip: board cleared, no CHECK.
    doFlip(4'd0);
    start = 1'b1; flip_req = 1'b1; flip_idx = 4'd5;
    tick();
    start = 1'b0; flip_req = 1'b0;
    checkAll("start_flip", 10'h000, 10'h000, 0, 0, 0, 0, 0);
    tick();
    checkAll("start_flip_after", 10'h000, 10'h000, 0, 0, 0, 0, 0);

    // Moves saturate at 255.
    for (int n = 0; n < 300; n++) begin
      doFlip(4'd0);
      doFlip(4'd1);
      waitIdle();
    end
    chk("sat.moves", 32'(moves), 32'd255);
    chk("sat.tile_up", 32'(tile_up), 32'd0);

    // Reset in the middle of HOLD aborts cleanly.
    doFlip(4'd0);
    doFlip(4'd1);
    tick();
    chk("hold.mismatch", 32'(mismatch), 32'd1);
    tick();
    chk("hold.busy", 32'(busy), 32'd1);
    chk("hold.moves", 32'(moves), 32'd255);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    checkAll("hold_reset", 10'h000, 10'h000, 0, 0, 0, 0, 0);
    tick();
    checkAll("hold_reset_after", 10'h000, 10'h000, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
